inst_fetch_stack: RTL and testbench
===================================

INST_FETCH_STACK -- requirements
Module: inst_fetch_stack

Interface
REQ-001 Parameter T, default 10, program counter width in bits (legal range 4..32).
REQ-002 Parameter DEPTH, default 4, return-stack depth in entries (legal range 1..16).
REQ-003 Parameters BASE1, BASE2, BASE3, defaults 'h080, 'h100, 'h180, start addresses of programs 1..3; program 0 always starts at 0.
REQ-004 Clk  input  1  sole clock; all state changes on rising edge only.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 Start  input  1  begin-program request from test bench; held high for one or more cycles.
REQ-007 ProgSel  input  2  program select, sampled while Start high.
REQ-008 Stall  input  1  hold PC and stack this cycle.
REQ-009 BranchAbs  input  1  unconditional absolute jump to Target.
REQ-010 BranchRelEn  input  1  conditional relative jump, taken when ALU_flag=1.
REQ-011 ALU_flag  input  1  branch condition from ALU.
REQ-012 Call  input  1  push return address, jump absolute to Target.
REQ-013 Ret  input  1  pop return address into PC.
REQ-014 Halt  input  1  current instruction is end-of-program.
REQ-015 Target  input  T  absolute address, or two's-complement offset for relative branch.
REQ-016 ProgCtr  output  T  program counter register.
REQ-017 Done  output  1  high while in HALT state.
REQ-018 StkOvf  output  1  sticky: Call attempted with stack full.
REQ-019 StkUnf  output  1  sticky: Ret attempted with stack empty.
REQ-020 StkDepth  output  $clog2(DEPTH+1)  current number of valid stack entries.

Function
REQ-021 States: IDLE (PC held at selected base), RUN (fetching), HALT (PC frozen, Done=1).
REQ-022 Start high in any state: next state IDLE, ProgCtr <= base[ProgSel] every cycle Start is high, stack emptied, StkOvf/StkUnf cleared.
REQ-023 IDLE with Start low: next state RUN, ProgCtr unchanged; first fetch address equals base of last sampled ProgSel.
REQ-024 RUN update priority, highest first: Halt, Stall, Ret, Call, BranchAbs, BranchRelEn&ALU_flag, increment.
REQ-025 Halt in RUN: ProgCtr held, next state HALT; Done rises the following cycle.
REQ-026 Stall in RUN: ProgCtr, stack, flags all held.
REQ-027 Ret, stack non-empty: ProgCtr <= top entry, StkDepth decrements.
REQ-028 Ret, stack empty: ProgCtr <= ProgCtr+1, StkUnf <= 1, depth stays 0.
REQ-029 Call, stack not full: push ProgCtr+1 (mod 2^T), ProgCtr <= Target, StkDepth increments.
REQ-030 Call, stack full (StkDepth=DEPTH): ProgCtr <= Target, stack contents unchanged, StkOvf <= 1.
REQ-031 Call and Ret together: Ret executes, Call ignored.
REQ-032 BranchAbs: ProgCtr <= Target.
REQ-033 BranchRelEn with ALU_flag=1: ProgCtr <= ProgCtr + sign-extended Target, modulo 2^T; with ALU_flag=0: increment.
REQ-034 Increment and all address arithmetic wrap modulo 2^T (all-ones + 1 -> 0).
REQ-035 HALT: all controls except Start ignored; ProgCtr, stack, flags held.
REQ-036 Control inputs other than Start and ProgSel ignored in IDLE.

Reset
REQ-037 Reset high: immediately (without clock) ProgCtr=0, state IDLE, stack empty, StkDepth=0, Done=0, StkOvf=0, StkUnf=0.
REQ-038 Reset has priority over Start and all other inputs; on deassertion the block is in IDLE with base 0.
REQ-039 Reset asserted mid-RUN or mid-HALT discards stack contents and flags.

Verification
REQ-040 Reset, Start=1 ProgSel=2 two cycles, release -> ProgCtr='h100 in IDLE, 'h101 after first RUN cycle.
REQ-041 RUN at PC 'h010, Call Target='h050 -> PC='h050, StkDepth=1; later Ret -> PC='h011, StkDepth=0.
REQ-042 DEPTH=4, five nested Calls -> StkDepth=4, StkOvf=1 after fifth; four Rets return correct addresses; fifth Ret -> StkUnf=1, PC increments.
REQ-043 PC='h020, BranchRelEn=1 Target=-3 (all-ones minus 2): ALU_flag=1 -> 'h01D; ALU_flag=0 -> 'h021; PC=all-ones increment -> 0.
REQ-044 Halt at PC 'h033 with BranchAbs also high -> PC stays 'h033, Done=1 next cycle, holds until Start.
REQ-045 Reset pulsed asynchronously between clock edges mid-RUN with StkDepth=2 -> outputs zero immediately, before next edge.

Source files
------------

// File: rtl/inst_fetch_stack.sv
// Instruction fetch unit: program counter with IDLE/RUN/HALT sequencing,
// absolute/relative branches and a small hardware return-address stack.
module inst_fetch_stack #(
    parameter int unsigned T     = 10,
    parameter int unsigned DEPTH = 4,
    parameter logic [31:0] BASE1 = 32'h080,
    parameter logic [31:0] BASE2 = 32'h100,
    parameter logic [31:0] BASE3 = 32'h180
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Start,
    input  logic [1:0]                   ProgSel,
    input  logic                         Stall,
    input  logic                         BranchAbs,
    input  logic                         BranchRelEn,
    input  logic                         ALU_flag,
    input  logic                         Call,
    input  logic                         Ret,
    input  logic                         Halt,
    input  logic [T-1:0]                 Target,
    output logic [T-1:0]                 ProgCtr,
    output logic                         Done,
    output logic                         StkOvf,
    output logic                         StkUnf,
    output logic [$clog2(DEPTH+1)-1:0]   StkDepth
);

    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t         state;
    logic [T-1:0]   stack [DEPTH];
    logic [T-1:0]   base_c;
    logic [T-1:0]   pc_inc_c;
    logic           stk_full_c;
    logic           stk_empty_c;

    // Start address of the selected program
    always_comb begin
        base_c = '0;
        case (ProgSel)
            2'd1:    base_c = T'(BASE1);
            2'd2:    base_c = T'(BASE2);
            2'd3:    base_c = T'(BASE3);
            default: base_c = '0;
        endcase
    end

    assign pc_inc_c    = ProgCtr + T'(1);
    assign stk_full_c  = (StkDepth == DW'(DEPTH));
    assign stk_empty_c = (StkDepth == '0);

    // Sequencer, PC update and return stack; Start overrides every state
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= S_IDLE;
            ProgCtr  <= '0;
            StkDepth <= '0;
            Done     <= 1'b0;
            StkOvf   <= 1'b0;
            StkUnf   <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                stack[i] <= '0;
            end
        end else if (Start) begin
            state    <= S_IDLE;
            ProgCtr  <= base_c;
            StkDepth <= '0;
            Done     <= 1'b0;
            StkOvf   <= 1'b0;
            StkUnf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (Halt) begin
                        state <= S_HALT;
                        Done  <= 1'b1;
                    end else if (Stall) begin
                        state <= S_RUN;
                    end else if (Ret) begin
                        if (stk_empty_c) begin
                            ProgCtr <= pc_inc_c;
                            StkUnf  <= 1'b1;
                        end else begin
                            ProgCtr  <= stack[AW'(StkDepth - DW'(1))];
                            StkDepth <= StkDepth - DW'(1);
                        end
                    end else if (Call) begin
                        ProgCtr <= Target;
                        if (stk_full_c) begin
                            StkOvf <= 1'b1;
                        end else begin
                            stack[AW'(StkDepth)] <= pc_inc_c;
                            StkDepth             <= StkDepth + DW'(1);
                        end
                    end else if (BranchAbs) begin
                        ProgCtr <= Target;
                    end else if (BranchRelEn && ALU_flag) begin
                        // Same-width add is the sign-extended offset modulo 2^T
                        ProgCtr <= ProgCtr + Target;
                    end else begin
                        ProgCtr <= pc_inc_c;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_stack.sv
// Self-checking bench for inst_fetch_stack: vector table plus return-stack
// model sequences and an asynchronous reset check.
module tb_inst_fetch_stack;

    localparam int unsigned T     = 10;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = $clog2(DEPTH + 1);

    localparam logic [6:0] NONE  = 7'b0000000;
    localparam logic [6:0] STALL = 7'b1000000;
    localparam logic [6:0] BABS  = 7'b0100000;
    localparam logic [6:0] BREL  = 7'b0010000;
    localparam logic [6:0] FLAG  = 7'b0001000;
    localparam logic [6:0] CALL  = 7'b0000100;
    localparam logic [6:0] RET   = 7'b0000010;
    localparam logic [6:0] HALT  = 7'b0000001;

    typedef struct {
        string          name;
        logic           start;
        logic [1:0]     sel;
        logic [6:0]     ctl;
        logic [T-1:0]   target;
        logic [T-1:0]   pc;
        logic [DW-1:0]  depth;
        logic           done;
        logic           ovf;
        logic           unf;
    } vec_t;

    typedef struct {
        string          name;
        logic [T-1:0]   pc;
        logic [DW-1:0]  depth;
        logic           done;
        logic           ovf;
        logic           unf;
    } exp_t;

    logic           Clk;
    logic           Reset;
    logic           Start;
    logic [1:0]     ProgSel;
    logic           Stall;
    logic           BranchAbs;
    logic           BranchRelEn;
    logic           ALU_flag;
    logic           Call;
    logic           Ret;
    logic           Halt;
    logic [T-1:0]   Target;
    logic [T-1:0]   ProgCtr;
    logic           Done;
    logic           StkOvf;
    logic           StkUnf;
    logic [DW-1:0]  StkDepth;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];

    inst_fetch_stack #(.T(T), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel),
        .Stall(Stall), .BranchAbs(BranchAbs), .BranchRelEn(BranchRelEn),
        .ALU_flag(ALU_flag), .Call(Call), .Ret(Ret), .Halt(Halt),
        .Target(Target), .ProgCtr(ProgCtr), .Done(Done), .StkOvf(StkOvf),
        .StkUnf(StkUnf), .StkDepth(StkDepth)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic vec_t mk(string n, logic st, logic [1:0] sel, logic [6:0] ctl,
                                logic [T-1:0] tgt, logic [T-1:0] pc, logic [DW-1:0] d,
                                logic dn, logic ov, logic un);
        vec_t v;
        v.name = n; v.start = st; v.sel = sel; v.ctl = ctl; v.target = tgt;
        v.pc = pc; v.depth = d; v.done = dn; v.ovf = ov; v.unf = un;
        return v;
    endfunction

    task automatic cmp(string n, string f, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s got=%0h expected=%0h", n, f, act, req);
        end
    endtask

    // Pop the oldest expectation and compare against the current outputs
    task automatic check_now();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard empty got=%0d expected=1", sb.size());
            return;
        end
        e = sb.pop_front();
        cmp(e.name, "pc",    32'(ProgCtr),  32'(e.pc));
        cmp(e.name, "depth", 32'(StkDepth), 32'(e.depth));
        cmp(e.name, "done",  32'(Done),     32'(e.done));
        cmp(e.name, "ovf",   32'(StkOvf),   32'(e.ovf));
        cmp(e.name, "unf",   32'(StkUnf),   32'(e.unf));
    endtask

    task automatic push_exp(string n, logic [T-1:0] pc, logic [DW-1:0] d,
                            logic dn, logic ov, logic un);
        exp_t e;
        e.name = n; e.pc = pc; e.depth = d; e.done = dn; e.ovf = ov; e.unf = un;
        sb.push_back(e);
    endtask

    task automatic apply(vec_t v);
        Start       = v.start;
        ProgSel     = v.sel;
        Stall       = v.ctl[6];
        BranchAbs   = v.ctl[5];
        BranchRelEn = v.ctl[4];
        ALU_flag    = v.ctl[3];
        Call        = v.ctl[2];
        Ret         = v.ctl[1];
        Halt        = v.ctl[0];
        Target      = v.target;
        push_exp(v.name, v.pc, v.depth, v.done, v.ovf, v.unf);
        @(posedge Clk);
        #1;
        check_now();
    endtask

    vec_t           tbl[$];
    logic [T-1:0]   mpc;
    logic [T-1:0]   mstk[$];
    logic [T-1:0]   tgt;
    logic           movf;
    logic           munf;

    initial begin
        Reset = 1'b0; Start = 1'b0; ProgSel = 2'd0; Stall = 1'b0;
        BranchAbs = 1'b0; BranchRelEn = 1'b0; ALU_flag = 1'b0;
        Call = 1'b0; Ret = 1'b0; Halt = 1'b0; Target = '0;

        #1 Reset = 1'b1;
        #1;
        push_exp("reset", '0, '0, 1'b0, 1'b0, 1'b0);
        check_now();
        @(posedge Clk);
        #1 Reset = 1'b0;

        tbl.push_back(mk("start_a",     1, 2, NONE,        10'h000, 10'h100, 0, 0, 0, 0));
        tbl.push_back(mk("start_b",     1, 2, NONE,        10'h000, 10'h100, 0, 0, 0, 0));
        tbl.push_back(mk("idle_run",    0, 0, NONE,        10'h000, 10'h100, 0, 0, 0, 0));
        tbl.push_back(mk("run_inc",     0, 0, NONE,        10'h000, 10'h101, 0, 0, 0, 0));
        tbl.push_back(mk("babs_010",    0, 0, BABS,        10'h010, 10'h010, 0, 0, 0, 0));
        tbl.push_back(mk("call_050",    0, 0, CALL,        10'h050, 10'h050, 1, 0, 0, 0));
        tbl.push_back(mk("inc_051",     0, 0, NONE,        10'h000, 10'h051, 1, 0, 0, 0));
        tbl.push_back(mk("stall",       0, 0, STALL|BABS|CALL, 10'h3AA, 10'h051, 1, 0, 0, 0));
        tbl.push_back(mk("ret_011",     0, 0, RET,         10'h000, 10'h011, 0, 0, 0, 0));
        tbl.push_back(mk("babs_020",    0, 0, BABS,        10'h020, 10'h020, 0, 0, 0, 0));
        tbl.push_back(mk("brel_taken",  0, 0, BREL|FLAG,   10'h3FD, 10'h01D, 0, 0, 0, 0));
        tbl.push_back(mk("babs_020b",   0, 0, BABS,        10'h020, 10'h020, 0, 0, 0, 0));
        tbl.push_back(mk("brel_not",    0, 0, BREL,        10'h3FD, 10'h021, 0, 0, 0, 0));
        tbl.push_back(mk("babs_3ff",    0, 0, BABS,        10'h3FF, 10'h3FF, 0, 0, 0, 0));
        tbl.push_back(mk("wrap",        0, 0, NONE,        10'h000, 10'h000, 0, 0, 0, 0));
        tbl.push_back(mk("call_0aa",    0, 0, CALL,        10'h0AA, 10'h0AA, 1, 0, 0, 0));
        tbl.push_back(mk("callret",     0, 0, CALL|RET,    10'h155, 10'h001, 0, 0, 0, 0));
        tbl.push_back(mk("ret_unf",     0, 0, RET,         10'h000, 10'h002, 0, 0, 0, 1));
        tbl.push_back(mk("start_sel1",  1, 1, NONE,        10'h000, 10'h080, 0, 0, 0, 0));
        tbl.push_back(mk("idle_ignore", 0, 0, BABS|CALL|RET|HALT, 10'h3AB, 10'h080, 0, 0, 0, 0));
        tbl.push_back(mk("babs_033",    0, 0, BABS,        10'h033, 10'h033, 0, 0, 0, 0));
        tbl.push_back(mk("halt",        0, 0, HALT|BABS,   10'h077, 10'h033, 0, 1, 0, 0));
        tbl.push_back(mk("halt_hold",   0, 0, CALL|BABS,   10'h111, 10'h033, 0, 1, 0, 0));
        tbl.push_back(mk("halt_ret",    0, 0, RET|BREL|FLAG, 10'h005, 10'h033, 0, 1, 0, 0));
        tbl.push_back(mk("start_sel3",  1, 3, NONE,        10'h000, 10'h180, 0, 0, 0, 0));
        tbl.push_back(mk("start_sel0",  1, 0, NONE,        10'h000, 10'h000, 0, 0, 0, 0));
        tbl.push_back(mk("idle_run2",   0, 0, NONE,        10'h000, 10'h000, 0, 0, 0, 0));
        tbl.push_back(mk("run_001",     0, 0, NONE,        10'h000, 10'h001, 0, 0, 0, 0));

        foreach (tbl[i]) apply(tbl[i]);

        // Nested calls past the stack depth, then unwind one past empty
        mpc = 10'h001; movf = 1'b0; munf = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tgt = T'(32'h040 + 32'(i) * 32'h10);
            if (mstk.size() < int'(DEPTH)) mstk.push_back(mpc + T'(1));
            else movf = 1'b1;
            mpc = tgt;
            apply(mk($sformatf("call%0d", i), 0, 0, CALL, tgt, mpc,
                     DW'(mstk.size()), 0, movf, munf));
        end
        for (int i = 0; i < 5; i++) begin
            if (mstk.size() > 0) mpc = mstk.pop_back();
            else begin
                mpc  = mpc + T'(1);
                munf = 1'b1;
            end
            apply(mk($sformatf("ret%0d", i), 0, 0, RET, 10'h000, mpc,
                     DW'(mstk.size()), 0, movf, munf));
        end

        // Build depth 2, then reset between edges
        apply(mk("pre_call_a", 0, 0, CALL, 10'h200, 10'h200, 1, 0, movf, munf));
        apply(mk("pre_call_b", 0, 0, CALL, 10'h300, 10'h300, 2, 0, movf, munf));
        Call = 1'b0;
        #2 Reset = 1'b1;
        #1;
        push_exp("async_rst", '0, '0, 1'b0, 1'b0, 1'b0);
        check_now();
        Start = 1'b1; ProgSel = 2'd2;
        @(posedge Clk);
        #1;
        push_exp("rst_prio", '0, '0, 1'b0, 1'b0, 1'b0);
        check_now();
        #2 Reset = 1'b0;
        apply(mk("post_rst_idle", 0, 0, NONE, 10'h000, 10'h000, 0, 0, 0, 0));
        apply(mk("post_rst_run",  0, 0, NONE, 10'h000, 10'h001, 0, 0, 0, 0));

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard leftover got=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
